// File: rtl/int_claim_arbiter.sv
// Prioritising interrupt gateway with a claim/complete handshake toward one hart.
// Synchronises raw lines, latches edge/level requests and serialises service per source.
module int_claim_arbiter #(
  parameter int NUM_SRC     = 8,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_SRC + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_in,
  input  logic [NUM_SRC-1:0]        src_edge,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]         threshold,
  output logic                      irq_out,
  input  logic                      claim_req,
  output logic                      claim_ack,
  output logic [ID_W-1:0]           claim_id,
  input  logic                      complete_valid,
  input  logic [ID_W-1:0]           complete_id,
  output logic                      busy
);

  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int CNT_W  = $clog2(SETTLE + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_r;
  logic [NUM_SRC-1:0] hist_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] in_service_r;
  logic [CNT_W-1:0]   settle_r;
  state_t             state_r;
  logic               irq_out_r;
  logic               claim_ack_r;
  logic [ID_W-1:0]    claim_id_r;
  logic               busy_r;

  logic [NUM_SRC-1:0] synced_s;
  logic               armed_s;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] claim_mask_s;
  logic [NUM_SRC-1:0] complete_mask_s;
  logic [NUM_SRC-1:0] in_service_next_s;
  logic [NUM_SRC-1:0] pending_next_s;
  logic [PRIO_W-1:0]  best_prio_s;
  logic [ID_W-1:0]    win_id_s;
  state_t             state_next_s;
  logic               claim_go_s;

  assign synced_s = sync_r[SYNC_STAGES-1];
  // Edge detection stays disarmed until the synchroniser has flushed after reset,
  // so a line already high at release is not mistaken for a rising edge.
  assign armed_s  = (settle_r == CNT_W'(SETTLE));

  // Input synchroniser, edge history and post-reset settle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_r   <= '0;
      hist_r   <= '0;
      settle_r <= '0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], src_in};
      hist_r   <= synced_s;
      settle_r <= armed_s ? settle_r : settle_r + CNT_W'(1);
    end
  end

  // Eligibility and highest-priority winner selection (ties to lowest index).
  always_comb begin
    rise_s      = synced_s & ~hist_r & {NUM_SRC{armed_s}};
    eligible_s  = '0;
    best_prio_s = '0;
    win_id_s    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible_s[i] = pending_r[i] & src_enable[i] & ~in_service_r[i] &
                      (src_prio[i*PRIO_W +: PRIO_W] > threshold);
      if (eligible_s[i] && (src_prio[i*PRIO_W +: PRIO_W] > best_prio_s)) begin
        best_prio_s = src_prio[i*PRIO_W +: PRIO_W];
        win_id_s    = ID_W'(i + 1);
      end else begin
        win_id_s    = win_id_s;
      end
    end
  end

  // Claim FSM next state; a claim is only accepted from IDLE.
  always_comb begin
    state_next_s = state_r;
    claim_go_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (claim_req) begin
          claim_go_s   = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-source claim/complete masks and next pending / in-service state.
  // Completion is applied before the claim; eligibility uses the old in_service.
  always_comb begin
    claim_mask_s      = '0;
    complete_mask_s   = '0;
    in_service_next_s = '0;
    pending_next_s    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask_s[i]      = claim_go_s && (win_id_s == ID_W'(i + 1));
      complete_mask_s[i]   = complete_valid && (complete_id == ID_W'(i + 1));
      in_service_next_s[i] = (in_service_r[i] & ~complete_mask_s[i]) | claim_mask_s[i];
      if (src_edge[i]) begin
        pending_next_s[i] = (pending_r[i] & ~claim_mask_s[i]) | rise_s[i];
      end else begin
        pending_next_s[i] = synced_s[i] & ~in_service_next_s[i];
      end
    end
  end

  // Source state, FSM state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_r    <= '0;
      in_service_r <= '0;
      state_r      <= ST_IDLE;
      irq_out_r    <= 1'b0;
      claim_ack_r  <= 1'b0;
      claim_id_r   <= '0;
      busy_r       <= 1'b0;
    end else begin
      pending_r    <= pending_next_s;
      in_service_r <= in_service_next_s;
      state_r      <= state_next_s;
      irq_out_r    <= |eligible_s;
      claim_ack_r  <= claim_go_s;
      claim_id_r   <= claim_go_s ? win_id_s : '0;
      busy_r       <= |in_service_next_s;
    end
  end

  assign irq_out   = irq_out_r;
  assign claim_ack = claim_ack_r;
  assign claim_id  = claim_id_r;
  assign busy      = busy_r;

endmodule
